wb_sequencer: RTL and testbench

- Writeback-stage controller for the register-file write-data mux.
- Accepts one writeback request per instruction from execute and registers the mux select (MemToReg) and RegWrite.
- Sequences variable-latency data-memory loads by stalling upstream until read data is valid, then commits it.
- Sits between execute/memory control and the write-data mux plus register-file write port.

---
 rtl/wb_sequencer_pkg.sv | 15 +
 rtl/wb_sequencer.sv | 133 +++++++++++++
 tb/tb_wb_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: write-data mux select
// encodings and the controller state type.
package wb_sequencer_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_PC  = 2'b01;
   localparam logic [1:0] WB_MEM = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_MEM = 2'b01,
      WRITE    = 2'b10
   } wb_state_e;

endpackage

// File: rtl/wb_sequencer.sv
// Writeback-stage controller: registers MemToReg/RegWrite per request and stalls
// upstream on loads until read data is valid. Optional load timeout: WB_TIMEOUT_EN.
module wb_sequencer
   import wb_sequencer_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter bit ZERO_REG_RO = 1'b1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        wb_sel,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              mem_rd_valid,
   output logic              mem_rd_ack,
   output logic [1:0]        MemToReg,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              stall,
   output logic              err
);

   wb_state_e         state_q, state_d;
   logic [1:0]        mem_to_reg_q, mem_to_reg_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic              ack_q, ack_d;
   logic              ld_we_q, ld_we_d;
   logic              accept;
   logic              eff_we;
   logic              tmo_hit;

   assign in_ready = (state_q != WAIT_MEM);
   assign stall    = ~in_ready;
   assign accept   = in_valid && in_ready;
   // A write to r0 is dropped here so loads to r0 still drain memory normally.
   assign eff_we   = reg_write && !(ZERO_REG_RO && (rd_addr == '0));

`ifdef WB_TIMEOUT_EN
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   assign tmo_hit = (state_q == WAIT_MEM) && !mem_rd_valid
                    && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // Counter sits at zero outside WAIT_MEM, so every wait starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == WAIT_MEM) ? cnt_q + 1'b1 : '0;
         err_q <= err_q | tmo_hit;
      end
   end

   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
   // Constant 0; the comparison only keeps MEM_TIMEOUT referenced in this build.
   assign err     = (MEM_TIMEOUT < 0);
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d      = IDLE;
      reg_write_d  = 1'b0;
      mem_to_reg_d = WB_ALU;
      wb_addr_d    = wb_addr_q;
      ack_d        = 1'b0;
      ld_we_d      = ld_we_q;

      unique case (state_q)
         IDLE, WRITE: begin
            if (accept) begin
               if (wb_sel == WB_MEM) begin
                  state_d   = WAIT_MEM;
                  wb_addr_d = rd_addr;
                  ld_we_d   = eff_we;
               end else if (eff_we) begin
                  state_d      = WRITE;
                  reg_write_d  = 1'b1;
                  wb_addr_d    = rd_addr;
                  mem_to_reg_d = (wb_sel == WB_PC) ? WB_PC : WB_ALU;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rd_valid) begin
               state_d      = WRITE;
               ack_d        = 1'b1;
               reg_write_d  = ld_we_q;
               mem_to_reg_d = ld_we_q ? WB_MEM : WB_ALU;
            end else if (tmo_hit) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_MEM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= WB_ALU;
         wb_addr_q    <= '0;
         ack_q        <= 1'b0;
         ld_we_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q      <= state_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         wb_addr_q    <= wb_addr_d;
         ack_q        <= ack_d;
         ld_we_q      <= ld_we_d;
      end
   end

   assign RegWrite   = reg_write_q;
   assign MemToReg   = mem_to_reg_q;
   assign wb_addr    = wb_addr_q;
   assign mem_rd_ack = ack_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios plus randomized
// traffic against a transaction-level model of the writeback rules.
module tb_wb_sequencer;

   localparam int ADDR_W      = 5;
   localparam int MEM_TIMEOUT = 15;
   localparam bit ZERO_REG_RO = 1'b1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        wb_sel;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_addr;
   logic              mem_rd_valid;
   logic              mem_rd_ack;
   logic [1:0]        MemToReg;
   logic              RegWrite;
   logic [ADDR_W-1:0] wb_addr;
   logic              stall;
   logic              err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: at most one outstanding load, plus the expected outputs.
   bit                m_pend;
   logic [ADDR_W-1:0] m_addr;
   bit                m_we;
   int                m_waits;
   bit                m_err;
   bit                e_rw;
   logic [1:0]        e_sel;
   logic [ADDR_W-1:0] e_addr;
   bit                e_ack;

   wb_sequencer #(
      .ADDR_W      (ADDR_W),
      .ZERO_REG_RO (ZERO_REG_RO),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .wb_sel       (wb_sel),
      .reg_write    (reg_write),
      .rd_addr      (rd_addr),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_ack   (mem_rd_ack),
      .MemToReg     (MemToReg),
      .RegWrite     (RegWrite),
      .wb_addr      (wb_addr),
      .stall        (stall),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_pend  = 1'b0;
      m_addr  = '0;
      m_we    = 1'b0;
      m_waits = 0;
      m_err   = 1'b0;
   endtask

   // One clock: drive inputs, check the ready side, predict, clock, check outputs.
   task automatic step(input bit v, input logic [1:0] sel, input bit rw,
                       input logic [ADDR_W-1:0] rd, input bit mv);
      bit we;
      in_valid     = v;
      wb_sel       = sel;
      reg_write    = rw;
      rd_addr      = rd;
      mem_rd_valid = mv;
      #1;
      check("in_ready", in_ready, !m_pend);
      check("stall", stall, m_pend);

      e_rw  = 1'b0;
      e_sel = 2'b00;
      e_addr = '0;
      e_ack = 1'b0;
      if (m_pend) begin
         if (mv) begin
            e_ack  = 1'b1;
            e_rw   = m_we;
            e_sel  = m_we ? 2'b10 : 2'b00;
            e_addr = m_addr;
            m_pend = 1'b0;
         end else begin
            m_waits++;
`ifdef WB_TIMEOUT_EN
            if (m_waits == MEM_TIMEOUT) begin
               m_err  = 1'b1;
               m_pend = 1'b0;
            end
`endif
         end
      end else if (v) begin
         we = rw && !(ZERO_REG_RO && rd == 0);
         if (sel == 2'b10) begin
            m_pend  = 1'b1;
            m_addr  = rd;
            m_we    = we;
            m_waits = 0;
         end else if (we) begin
            e_rw   = 1'b1;
            e_sel  = (sel == 2'b01) ? 2'b01 : 2'b00;
            e_addr = rd;
         end
      end

      @(posedge clk);
      #1;
      check("RegWrite", RegWrite, e_rw);
      check("MemToReg", MemToReg, e_sel);
      check("mem_rd_ack", mem_rd_ack, e_ack);
      check("err", err, m_err);
      if (e_rw) check("wb_addr", wb_addr, e_addr);
   endtask

   // Asynchronous reset taken between edges; outputs must clear without a clock.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_RegWrite", RegWrite, 0);
      check("rst_MemToReg", MemToReg, 0);
      check("rst_wb_addr", wb_addr, 0);
      check("rst_ack", mem_rd_ack, 0);
      check("rst_err", err, 0);
      check("rst_in_ready", in_ready, 1);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      wb_sel       = 2'b00;
      reg_write    = 1'b0;
      rd_addr      = '0;
      mem_rd_valid = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // ALU write to r5, then idle
      step(1, 2'b00, 1, 5'd5, 0);
      step(0, 2'b00, 0, 5'd0, 0);

      // back-to-back: pc_next to r3, then 11 (normalised to ALU) to r7
      step(1, 2'b01, 1, 5'd3, 0);
      step(1, 2'b11, 1, 5'd7, 0);
      step(0, 2'b00, 0, 5'd0, 0);

      // load to r9 with data valid four cycles after accept
      step(1, 2'b10, 1, 5'd9, 0);
      for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 5'd0, 0);
      step(0, 2'b00, 0, 5'd0, 1);
      step(0, 2'b00, 0, 5'd0, 0);

      // stray mem_rd_valid while idle must not ack
      step(0, 2'b00, 0, 5'd0, 1);

      // zero register: load acks without write, ALU write suppressed
      step(1, 2'b10, 1, 5'd0, 0);
      step(0, 2'b00, 0, 5'd0, 1);
      step(1, 2'b00, 1, 5'd0, 0);
      step(0, 2'b00, 0, 5'd0, 0);

      // reset mid-wait, then late data must not be acknowledged
      step(1, 2'b10, 1, 5'd12, 0);
      step(0, 2'b00, 0, 5'd0, 0);
      do_reset();
      step(0, 2'b00, 0, 5'd0, 1);
      step(0, 2'b00, 0, 5'd0, 0);

`ifdef WB_TIMEOUT_EN
      // load that never returns data: abort with sticky err
      step(1, 2'b10, 1, 5'd4, 0);
      for (int i = 0; i < MEM_TIMEOUT + 3; i++) step(0, 2'b00, 0, 5'd0, 0);
      step(1, 2'b00, 1, 5'd6, 0);
      step(0, 2'b00, 0, 5'd0, 1);
      do_reset();
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [ADDR_W-1:0] rd;
         rd = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom);
         step(($urandom_range(0, 9) < 6), 2'($urandom), ($urandom_range(0, 9) < 8),
              rd, ($urandom_range(0, 99) < 35));
      end

      do_reset();
      step(0, 2'b00, 0, 5'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
